// File: rtl/svc_rv_mmio_mul_pkg.sv
// Shared constants and types for the MMIO iterative multiplier.
package svc_rv_mmio_mul_pkg;

    localparam int unsigned IO_AW   = 10;
    localparam int unsigned DATA_W  = 32;
    localparam int unsigned PROD_W  = 64;
    localparam int unsigned CNT_W   = 6;

    // Word-index offsets (byte offset >> 2)
    localparam logic [IO_AW-1:0] REG_A      = IO_AW'(0);
    localparam logic [IO_AW-1:0] REG_B      = IO_AW'(1);
    localparam logic [IO_AW-1:0] REG_CTRL   = IO_AW'(2);
    localparam logic [IO_AW-1:0] REG_STATUS = IO_AW'(3);
    localparam logic [IO_AW-1:0] REG_RES_LO = IO_AW'(4);
    localparam logic [IO_AW-1:0] REG_RES_HI = IO_AW'(5);

    // STATUS bit positions
    localparam int unsigned STAT_BUSY = 0;
    localparam int unsigned STAT_DONE = 1;
    localparam int unsigned STAT_ERR  = 2;

    // CTRL bit positions
    localparam int unsigned CTRL_A_SIGNED = 0;
    localparam int unsigned CTRL_B_SIGNED = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } mul_state_e;

    // Magnitude of an operand, treating it as two's complement when sgn is set.
    function automatic logic [DATA_W-1:0] mag32(input logic [DATA_W-1:0] x, input logic sgn);
        return (sgn && x[DATA_W-1]) ? DATA_W'(-x) : x;
    endfunction

endpackage

// File: rtl/svc_rv_mul_iter.sv
// Iterative shift-add 32x32->64 multiplier: one multiplier bit per cycle, sign fix-up at the end.
module svc_rv_mul_iter
    import svc_rv_mmio_mul_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              a_signed,
    input  logic              b_signed,
    output logic              busy,
    output logic              valid_c,
    output logic [PROD_W-1:0] product
);

    mul_state_e        state;
    mul_state_e        state_next;
    logic              load;
    logic              step;
    logic              finish;
    logic [CNT_W-1:0]  cnt;
    logic [PROD_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [PROD_W-1:0] acc;
    logic              neg;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state: a start is taken in IDLE and also in FIX, so back-to-back operations chain
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (cnt == CNT_W'(DATA_W - 1)) state_next = ST_FIX;
            ST_FIX:  state_next = start ? ST_RUN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Control decode from the current state
    always_comb begin
        load    = 1'b0;
        step    = 1'b0;
        finish  = 1'b0;
        case (state)
            ST_IDLE: load = start;
            ST_RUN:  step = 1'b1;
            ST_FIX: begin
                finish = 1'b1;
                load   = start;
            end
            default: ;
        endcase
        valid_c = finish;
    end

    // Datapath: operand capture, shift-add iterations, signed fix-up into the product register
    always_ff @(posedge clk) begin
        if (rst) begin
            busy    <= 1'b0;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            neg     <= 1'b0;
            product <= '0;
        end else begin
            if (load) begin
                mcand  <= {{(PROD_W-DATA_W){1'b0}}, mag32(a, a_signed)};
                mplier <= mag32(b, b_signed);
                acc    <= '0;
                cnt    <= '0;
                neg    <= (a_signed & a[DATA_W-1]) ^ (b_signed & b[DATA_W-1]);
                busy   <= 1'b1;
            end else if (step) begin
                if (mplier[0]) acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= (cnt == CNT_W'(DATA_W - 1)) ? '0 : cnt + CNT_W'(1);
            end
            if (finish) begin
                product <= neg ? PROD_W'(-acc) : acc;
                if (!load) busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/svc_rv_mmio_mul.sv
// MMIO responder wrapping the iterative multiplier: decode, register file, W1C status, read mux.
module svc_rv_mmio_mul
    import svc_rv_mmio_mul_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        io_ren,
    input  logic [31:0] io_raddr,
    output logic [31:0] io_rdata,
    input  logic        io_wen,
    input  logic [31:0] io_waddr,
    input  logic [31:0] io_wdata,
    input  logic [3:0]  io_wstrb,
    output logic        done_irq
);

    logic [IO_AW-1:0]  raddr_w;
    logic [IO_AW-1:0]  waddr_w;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic              done;
    logic              err;
    logic              busy;
    logic              valid_c;
    logic [PROD_W-1:0] product;
    logic              start_c;
    logic              start_ok_c;
    logic              start_err_c;
    logic              w1c_c;
    logic [DATA_W-1:0] rmux_c;
    logic              unused;

    assign raddr_w = io_raddr[IO_AW+1:2];
    assign waddr_w = io_waddr[IO_AW+1:2];
    assign unused  = ^{io_raddr[31:IO_AW+2], io_raddr[1:0], io_waddr[31:IO_AW+2], io_waddr[1:0]};

    // Write-side decode; a start during the FIX cycle is not an error since the core takes it
    always_comb begin
        start_c     = io_wen && (waddr_w == REG_CTRL) && io_wstrb[0];
        w1c_c       = io_wen && (waddr_w == REG_STATUS) && io_wstrb[0];
        start_ok_c  = start_c && !(busy && !valid_c);
        start_err_c = start_c && busy && !valid_c;
    end

    svc_rv_mul_iter u_iter (
        .clk      (clk),
        .rst      (rst),
        .start    (start_c),
        .a        (a_reg),
        .b        (b_reg),
        .a_signed (io_wdata[CTRL_A_SIGNED]),
        .b_signed (io_wdata[CTRL_B_SIGNED]),
        .busy     (busy),
        .valid_c  (valid_c),
        .product  (product)
    );

    // Operand registers, byte-strobed; writes while busy only affect the next start
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
        end else if (io_wen) begin
            for (int i = 0; i < 4; i++) begin
                if (waddr_w == REG_A && io_wstrb[i]) a_reg[8*i +: 8] <= io_wdata[8*i +: 8];
                if (waddr_w == REG_B && io_wstrb[i]) b_reg[8*i +: 8] <= io_wdata[8*i +: 8];
            end
        end
    end

    // Sticky status flags: hardware set beats a same-cycle W1C
    always_ff @(posedge clk) begin
        if (rst) begin
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            if (valid_c)                                 done <= 1'b1;
            else if (start_ok_c)                         done <= 1'b0;
            else if (w1c_c && io_wdata[STAT_DONE])       done <= 1'b0;

            if (start_err_c)                             err  <= 1'b1;
            else if (w1c_c && io_wdata[STAT_ERR])        err  <= 1'b0;
        end
    end

    // Read mux over pre-write register values
    always_comb begin
        rmux_c = '0;
        case (raddr_w)
            REG_A:      rmux_c = a_reg;
            REG_B:      rmux_c = b_reg;
            REG_STATUS: begin
                rmux_c[STAT_BUSY] = busy;
                rmux_c[STAT_DONE] = done;
                rmux_c[STAT_ERR]  = err;
            end
            REG_RES_LO: rmux_c = product[DATA_W-1:0];
            REG_RES_HI: rmux_c = product[PROD_W-1:DATA_W];
            default:    rmux_c = '0;
        endcase
    end

    // Registered read data, one cycle after io_ren
    always_ff @(posedge clk) begin
        if (rst)         io_rdata <= '0;
        else if (io_ren) io_rdata <= rmux_c;
    end

    assign done_irq = done;

endmodule

// File: tb/tb_svc_rv_mmio_mul.sv
// Self-checking bench for svc_rv_mmio_mul: table vectors, random operands vs. arithmetic model, timing corners.
module tb_svc_rv_mmio_mul;

    logic        clk = 1'b0;
    logic        rst;
    logic        io_ren;
    logic [31:0] io_raddr;
    logic [31:0] io_rdata;
    logic        io_wen;
    logic [31:0] io_waddr;
    logic [31:0] io_wdata;
    logic [3:0]  io_wstrb;
    logic        done_irq;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [31:0] OFF_A      = 32'h00;
    localparam logic [31:0] OFF_B      = 32'h04;
    localparam logic [31:0] OFF_CTRL   = 32'h08;
    localparam logic [31:0] OFF_STATUS = 32'h0C;
    localparam logic [31:0] OFF_LO     = 32'h10;
    localparam logic [31:0] OFF_HI     = 32'h14;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  ctrl;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    svc_rv_mmio_mul dut (
        .clk      (clk),
        .rst      (rst),
        .io_ren   (io_ren),
        .io_raddr (io_raddr),
        .io_rdata (io_rdata),
        .io_wen   (io_wen),
        .io_waddr (io_waddr),
        .io_wdata (io_wdata),
        .io_wstrb (io_wstrb),
        .done_irq (done_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: sign/zero-extend both operands to 64 bits and multiply
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] ctrl);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = ctrl[0] ? {{32{a[31]}}, a} : {32'h0, a};
        eb = ctrl[1] ? {{32{b[31]}}, b} : {32'h0, b};
        return ea * eb;
    endfunction

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        @(negedge clk);
        io_wen = 1'b1; io_waddr = addr; io_wdata = data; io_wstrb = strb;
        @(posedge clk);
        #1 io_wen = 1'b0;
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk);
        io_ren = 1'b1; io_raddr = addr;
        @(posedge clk);
        #1 io_ren = 1'b0;
        data = io_rdata;
    endtask

    // Poll STATUS until busy clears; returns the number of busy reads seen
    task automatic wait_idle(output int nbusy);
        logic [31:0] s;
        nbusy = 0;
        for (int k = 0; k < 80; k++) begin
            rd(OFF_STATUS, s);
            if (!s[0]) break;
            nbusy++;
        end
        check("poll_timeout_busy", {31'h0, s[0]}, 32'h0);
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic [1:0] ctrl,
                           output logic [31:0] lo, output logic [31:0] hi);
        int nb;
        wr(OFF_A, a, 4'hF);
        wr(OFF_B, b, 4'hF);
        wr(OFF_CTRL, {30'h0, ctrl}, 4'h1);
        wait_idle(nb);
        rd(OFF_LO, lo);
        rd(OFF_HI, hi);
    endtask

    initial begin
        vec_t        tbl[6];
        logic [31:0] lo, hi, s, d;
        logic [63:0] exp64;
        int          nb;

        tbl[0] = '{32'd6,        32'd7,        2'd0, 32'd42,       32'd0};
        tbl[1] = '{32'hFFFFFFFD, 32'd5,        2'd3, 32'hFFFFFFF1, 32'hFFFFFFFF};
        tbl[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'd0, 32'h00000001, 32'hFFFFFFFE};
        tbl[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'd3, 32'h00000001, 32'h00000000};
        tbl[4] = '{32'h80000000, 32'h80000000, 2'd3, 32'h00000000, 32'h40000000};
        tbl[5] = '{32'hFFFFFFFF, 32'd2,        2'd1, 32'hFFFFFFFE, 32'hFFFFFFFF};

        rst = 1'b1; io_ren = 1'b0; io_raddr = '0; io_wen = 1'b0;
        io_waddr = '0; io_wdata = '0; io_wstrb = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        check("rst_rdata", io_rdata, 32'h0);
        check("rst_irq", {31'h0, done_irq}, 32'h0);
        rd(OFF_A, s);      check("rst_a", s, 32'h0);
        rd(OFF_B, s);      check("rst_b", s, 32'h0);
        rd(OFF_STATUS, s); check("rst_status", s, 32'h0);
        rd(OFF_LO, s);     check("rst_lo", s, 32'h0);
        rd(OFF_HI, s);     check("rst_hi", s, 32'h0);

        // Table vectors
        foreach (tbl[i]) begin
            run_mul(tbl[i].a, tbl[i].b, tbl[i].ctrl, lo, hi);
            check($sformatf("tbl%0d_lo", i), lo, tbl[i].lo);
            check($sformatf("tbl%0d_hi", i), hi, tbl[i].hi);
            check($sformatf("tbl%0d_irq", i), {31'h0, done_irq}, 32'h1);
            rd(OFF_STATUS, s);
            check($sformatf("tbl%0d_status", i), s, 32'h2);
        end

        // Random operands against the model
        for (int r = 0; r < 20; r++) begin
            logic [31:0] ra, rb;
            logic [1:0]  rc;
            ra = $urandom; rb = $urandom; rc = 2'($urandom_range(0, 3));
            if (r == 0) ra = 32'h0;
            exp64 = model(ra, rb, rc);
            run_mul(ra, rb, rc, lo, hi);
            check($sformatf("rnd%0d_lo", r), lo, exp64[31:0]);
            check($sformatf("rnd%0d_hi", r), hi, exp64[63:32]);
        end

        // Byte strobes, and read-before-write in the same cycle
        wr(OFF_A, 32'hFFFFFFFF, 4'hF);
        wr(OFF_A, 32'h12345678, 4'b0101);
        rd(OFF_A, s); check("strb_a", s, 32'hFF34FF78);
        @(negedge clk);
        io_ren = 1'b1; io_raddr = OFF_A;
        io_wen = 1'b1; io_waddr = OFF_A; io_wdata = 32'hA5A5A5A5; io_wstrb = 4'hF;
        @(posedge clk);
        #1 io_ren = 1'b0; io_wen = 1'b0;
        check("rw_same_cycle", io_rdata, 32'hFF34FF78);
        rd(OFF_A, s); check("rw_after", s, 32'hA5A5A5A5);

        // Start while busy: err set, in-flight operands kept, previous result visible mid-run
        wr(OFF_B, 32'd4, 4'hF);
        wr(OFF_A, 32'd3, 4'hF);
        wr(OFF_CTRL, 32'h0, 4'h1);          // E0
        wr(OFF_A, 32'd9, 4'hF);             // E0+1
        rd(OFF_LO, s);                      // E0+2
        check("busy_prev_res", s, exp64[31:0]);
        @(posedge clk); #1;                 // E0+3
        @(posedge clk); #1;                 // E0+4
        wr(OFF_CTRL, 32'h0, 4'h1);          // E0+5
        wait_idle(nb);
        rd(OFF_LO, s);     check("busy_start_res", s, 32'd12);
        rd(OFF_STATUS, s); check("busy_start_status", s, 32'h6);
        wr(OFF_STATUS, 32'h6, 4'h1);
        rd(OFF_STATUS, s); check("w1c_clear", s, 32'h0);
        check("w1c_irq", {31'h0, done_irq}, 32'h0);

        // Exact busy window length; A is now 9
        wr(OFF_CTRL, 32'h0, 4'h1);
        wait_idle(nb);
        check("busy_cycles", 32'(nb), 32'd33);
        rd(OFF_LO, s); check("busy_cycles_res", s, 32'd36);

        // W1C of done at E0+33 loses against the set
        wr(OFF_CTRL, 32'h0, 4'h1);          // E0
        repeat (32) @(posedge clk);         // E0+32
        wr(OFF_STATUS, 32'h2, 4'h1);        // E0+33
        rd(OFF_STATUS, s); check("w1c_vs_set", s, 32'h2);

        // Reset mid-operation
        wr(OFF_A, 32'd100, 4'hF);
        wr(OFF_B, 32'd100, 4'hF);
        wr(OFF_CTRL, 32'h0, 4'h1);          // E0
        repeat (9) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;      // E0+10
        repeat (40) @(posedge clk);
        check("mid_rst_irq", {31'h0, done_irq}, 32'h0);
        rd(OFF_STATUS, s); check("mid_rst_status", s, 32'h0);
        rd(OFF_A, s);      check("mid_rst_a", s, 32'h0);
        rd(OFF_B, s);      check("mid_rst_b", s, 32'h0);
        rd(OFF_LO, s);     check("mid_rst_lo", s, 32'h0);
        rd(OFF_HI, s);     check("mid_rst_hi", s, 32'h0);
        run_mul(32'd2, 32'd3, 2'd0, lo, hi);
        check("post_rst_lo", lo, 32'd6);
        check("post_rst_hi", hi, 32'd0);

        // Unmapped and write-only offsets read zero; unmapped writes ignored
        wr(32'h20, 32'hDEADBEEF, 4'hF);
        rd(32'h20, d);     check("unmapped_rd", d, 32'h0);
        rd(OFF_CTRL, d);   check("ctrl_rd", d, 32'h0);
        rd(OFF_A, d);      check("unmapped_wr_a", d, 32'd2);
        rd(OFF_STATUS, d); check("unmapped_wr_status", d, 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
